// File: rtl/sw_array_ctrl.sv
// -----------------------------------------------------------------------------
// sw_array_ctrl
//
// Sequencer for a linear systolic array of Smith-Waterman PE cells. The query
// is already loaded, one character per PE. This block streams the target
// sequence into PE0 over a valid/ready handshake and drives the array-wide
// enable/lock/newLine controls. It records which PEs hold real cells, keeps
// the running maximum of their scores over the pass, and reports the final
// local-alignment score.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start             one-cycle pulse, begins a pass (honoured only in IDLE)
//   t_len, s_len      target length / active query length, sampled on start
//   t_valid, t_data   target character stream (A=0, C=1, G=2, T=3)
//   t_ready           target character consumed this cycle
//   pe_enable         array enable (0 clears all PE state)
//   pe_lock           array stall
//   pe_newLine        newLineIn to PE0 (first target character)
//   pe_t              tIn to PE0
//   pe_v              flattened vOut of every PE, PE i at [i*W +: W]
//   busy              pass in progress
//   done              one-cycle pulse, score valid
//   score             best local score of the last pass
// -----------------------------------------------------------------------------
`ifndef V_E_F_Bit
`define V_E_F_Bit 16
`endif

module sw_array_ctrl #(
  parameter int PE_NUM  = 64,
  parameter int LEN_BIT = 16,
  localparam int SW     = $clog2(PE_NUM) + 1,
  localparam int VW     = `V_E_F_Bit
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_BIT-1:0]   t_len,
  input  logic [SW-1:0]        s_len,
  input  logic                 t_valid,
  input  logic [1:0]           t_data,
  output logic                 t_ready,
  output logic                 pe_enable,
  output logic                 pe_lock,
  output logic                 pe_newLine,
  output logic [1:0]           pe_t,
  input  logic [PE_NUM*VW-1:0] pe_v,
  output logic                 busy,
  output logic                 done,
  output logic [VW-1:0]        score
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state, nextState;
  logic [LEN_BIT-1:0]  tLenQ;
  logic [SW-1:0]       sLenQ;
  logic [LEN_BIT-1:0]  cnt;
  logic [SW-1:0]       dcnt;
  logic [PE_NUM-1:0]   validSr;
  logic [VW-1:0]       best;
  logic [VW-1:0]       mmax;
  logic [VW-1:0]       bestNext;
  logic [SW-1:0]       sLenClamped;
  logic                lastChar;
  logic                lastDrain;

  assign lastChar    = (cnt == tLenQ - LEN_BIT'(1));
  assign lastDrain   = (dcnt == SW'(PE_NUM - 1));
  assign sLenClamped = (s_len > SW'(PE_NUM)) ? SW'(PE_NUM) : s_len;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = (t_len == '0) ? DONE : RUN;
      RUN:     if (t_valid && lastChar) nextState = DRAIN;
      DRAIN:   if (lastDrain) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (from the state register and the target handshake)
  // ---------------------------------------------------------------------------
  always_comb begin
    t_ready    = 1'b0;
    pe_lock    = 1'b0;
    pe_enable  = 1'b0;
    pe_newLine = 1'b0;
    pe_t       = 2'd0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      RUN: begin
        pe_enable  = 1'b1;
        busy       = 1'b1;
        t_ready    = t_valid;
        pe_lock    = !t_valid;
        pe_newLine = t_valid && (cnt == '0);
        pe_t       = t_valid ? t_data : 2'd0;
      end
      DRAIN: begin
        pe_enable = 1'b1;
        busy      = 1'b1;
      end
      DONE: begin
        pe_enable = 1'b1;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Best valid cell this cycle. Only PEs inside the active query that hold a
  // real cell take part; anything else on pe_v is stale or cleared state.
  // ---------------------------------------------------------------------------
  always_comb begin
    mmax = '0;
    for (int i = 0; i < PE_NUM; i++) begin
      if (validSr[i] && (i < int'(sLenQ)) && (pe_v[i*VW +: VW] > mmax))
        mmax = pe_v[i*VW +: VW];
    end
  end

  assign bestNext = (mmax > best) ? mmax : best;

  // ---------------------------------------------------------------------------
  // Datapath: counters, validity shift register, best/score.
  // validSr shifts in lockstep with the array: a cell enters PE0 on a consumed
  // character and moves one PE per unlocked cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tLenQ   <= '0;
      sLenQ   <= '0;
      cnt     <= '0;
      dcnt    <= '0;
      validSr <= '0;
      best    <= '0;
      score   <= '0;
    end else begin
      case (state)
        IDLE: begin
          validSr <= '0;
          if (start) begin
            tLenQ <= t_len;
            sLenQ <= sLenClamped;
            best  <= '0;
            cnt   <= '0;
            // An empty target goes straight to DONE, so score is loaded here.
            if (t_len == '0) score <= '0;
          end
        end
        RUN: begin
          if (t_valid) begin
            cnt     <= cnt + LEN_BIT'(1);
            validSr <= (validSr << 1) | PE_NUM'(1);
            best    <= bestNext;
            if (lastChar) dcnt <= '0;
          end
        end
        DRAIN: begin
          validSr <= validSr << 1;
          best    <= bestNext;
          dcnt    <= dcnt + SW'(1);
          // Score takes the final drain cycle's contribution as it enters DONE.
          if (lastDrain) score <= bestNext;
        end
        DONE: begin
          validSr <= validSr << 1;
        end
        default: ;
      endcase
    end
  end

endmodule
